// File: rtl/esn7e_demo_system_nios2_qsys_div_cell_if.sv
// Start/done handshake and operand/result bus between the CPU stall logic
// (master) and the iterative divide cell (slave).
interface esn7e_demo_system_nios2_qsys_div_cell_if;
  logic [31:0] A_div_src1;
  logic [31:0] A_div_src2;
  logic        A_div_signed;
  logic        A_div_start;
  logic        A_div_busy;
  logic        A_div_done;
  logic [31:0] A_div_cell_result;
  logic [31:0] A_div_cell_remainder;

  modport master (
    output A_div_src1, A_div_src2, A_div_signed, A_div_start,
    input  A_div_busy, A_div_done, A_div_cell_result, A_div_cell_remainder
  );

  modport slave (
    input  A_div_src1, A_div_src2, A_div_signed, A_div_start,
    output A_div_busy, A_div_done, A_div_cell_result, A_div_cell_remainder
  );
endinterface

// File: rtl/esn7e_demo_system_nios2_qsys_div_cell.sv
// Radix-2 restoring 32-bit divider (div/divu): one quotient bit per cycle,
// fixed 33-edge latency from accepted start to done.
module esn7e_demo_system_nios2_qsys_div_cell (
  input  logic clk,
  input  logic reset_n,
  esn7e_demo_system_nios2_qsys_div_cell_if.slave div_if
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] src1_q, src1_d;
  logic [31:0] result_q, result_d;
  logic [31:0] remainder_q, remainder_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic        dz_q, dz_d;

  logic        accept;
  logic        busy;
  logic        done;
  logic [31:0] src1_abs;
  logic [31:0] src2_abs;
  logic [32:0] shifted;
  logic [32:0] trial;

  // busy is low in IDLE and DONE, so a start in the DONE cycle chains directly
  assign accept = div_if.A_div_start & ((state_q == IDLE) | (state_q == DONE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (count_q == 5'd0) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = accept ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CALC) | (state_q == FIX);
    done = (state_q == DONE);
  end

  assign div_if.A_div_busy           = busy;
  assign div_if.A_div_done           = done;
  assign div_if.A_div_cell_result    = result_q;
  assign div_if.A_div_cell_remainder = remainder_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q     <= 5'd0;
      rem_q       <= 33'd0;
      dvd_q       <= 32'd0;
      dvs_q       <= 32'd0;
      src1_q      <= 32'd0;
      result_q    <= 32'd0;
      remainder_q <= 32'd0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      count_q     <= count_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      src1_q      <= src1_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      dz_q        <= dz_d;
    end
  end

  always_comb begin
    src1_abs = (div_if.A_div_signed & div_if.A_div_src1[31]) ? -div_if.A_div_src1 : div_if.A_div_src1;
    src2_abs = (div_if.A_div_signed & div_if.A_div_src2[31]) ? -div_if.A_div_src2 : div_if.A_div_src2;

    // The dividend register doubles as the quotient: its MSB feeds the
    // remainder while the new quotient bit enters at the LSB.
    shifted = {rem_q[31:0], dvd_q[31]};
    trial   = shifted - {1'b0, dvs_q};

    count_d     = count_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    src1_d      = src1_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    dz_d        = dz_q;

    if (accept) begin
      dvd_d   = src1_abs;
      dvs_d   = src2_abs;
      src1_d  = div_if.A_div_src1;
      q_neg_d = div_if.A_div_signed & (div_if.A_div_src1[31] ^ div_if.A_div_src2[31]);
      r_neg_d = div_if.A_div_signed & div_if.A_div_src1[31];
      dz_d    = (div_if.A_div_src2 == 32'd0);
      rem_d   = 33'd0;
      count_d = 5'd31;
    end else if (state_q == CALC) begin
      rem_d   = trial[32] ? shifted : trial;
      dvd_d   = {dvd_q[30:0], ~trial[32]};
      count_d = count_q - 5'd1;
    end else if (state_q == FIX) begin
      if (dz_q) begin
        result_d    = 32'hFFFF_FFFF;
        remainder_d = src1_q;
      end else begin
        result_d    = q_neg_q ? -dvd_q : dvd_q;
        remainder_d = r_neg_q ? -rem_q[31:0] : rem_q[31:0];
      end
    end
  end

endmodule
